// File: rtl/vls_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vls_sequencer_pkg
// Description : Shared types and constants for the vector load/store
//               sequencer: opcodes, FSM state encoding, default sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package vls_sequencer_pkg;

  // Default geometry of the vector register file and memory port
  localparam int unsigned C_VLS_NELEM = 16;
  localparam int unsigned C_VLS_WIDTH = 16;
  localparam int unsigned C_VLS_AW    = 16;
  localparam int unsigned C_VLS_EW    = 4;

  // Instruction opcodes handled by the sequencer
  localparam logic [3:0] C_OP_VLD = 4'b0100;
  localparam logic [3:0] C_OP_VST = 4'b0101;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } vls_state_e;

endpackage : vls_sequencer_pkg
`default_nettype wire

// File: rtl/vls_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : vls_addr_gen
// Description : Holds the effective address and the issue index of a vector
//               transfer. Presents the issue-phase address/index and the same
//               values delayed by one cycle for the retire phase, together
//               with a last-element flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vls_addr_gen import vls_sequencer_pkg::*; #(
  parameter int unsigned NELEM = C_VLS_NELEM,
  parameter int unsigned AW    = C_VLS_AW,
  parameter int unsigned EW    = C_VLS_EW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,      // start a new transfer
  input  logic [AW-1:0] base_i,
  input  logic [5:0]    offset_i,
  output logic          iss_en_o,    // an element is issued this cycle
  output logic [AW-1:0] iss_addr_o,
  output logic [EW-1:0] iss_idx_o,
  output logic          ret_vld_o,   // an element retires this cycle
  output logic [AW-1:0] ret_addr_o,
  output logic [EW-1:0] ret_idx_o,
  output logic          ret_last_o   // retiring element is the final one
);

  localparam logic [EW-1:0] C_LAST = EW'(NELEM - 1);
  localparam logic [EW-1:0] C_ONE  = {{(EW-1){1'b0}}, 1'b1};

  logic [AW-1:0] ea_q, ea_d;
  logic [EW-1:0] idx_q, idx_d;
  logic          iss_en_q, iss_en_d;
  logic          ret_vld_q, ret_vld_d;
  logic [AW-1:0] ret_addr_q, ret_addr_d;
  logic [EW-1:0] ret_idx_q, ret_idx_d;
  logic          ret_last_q, ret_last_d;

  logic [AW-1:0] w_iss_addr;
  logic          w_iss_last;

  // Address arithmetic wraps modulo 2^AW by construction
  assign w_iss_addr = ea_q + {{(AW-EW){1'b0}}, idx_q};
  assign w_iss_last = (idx_q == C_LAST);

  // Next-state: load EA on start, step the index while issuing, and delay
  // the issue-phase address/index by one cycle for the retire phase
  always_comb begin
    ea_d       = ea_q;
    idx_d      = idx_q;
    iss_en_d   = iss_en_q;
    ret_vld_d  = iss_en_q;
    ret_addr_d = w_iss_addr;
    ret_idx_d  = idx_q;
    ret_last_d = w_iss_last;
    if (load_i) begin
      ea_d      = base_i + {{(AW-6){1'b0}}, offset_i};
      idx_d     = '0;
      iss_en_d  = 1'b1;
      ret_vld_d = 1'b0;
    end else if (iss_en_q) begin
      idx_d = idx_q + C_ONE;
      if (w_iss_last) begin
        iss_en_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ea_q       <= '0;
      idx_q      <= '0;
      iss_en_q   <= 1'b0;
      ret_vld_q  <= 1'b0;
      ret_addr_q <= '0;
      ret_idx_q  <= '0;
      ret_last_q <= 1'b0;
    end else begin
      ea_q       <= ea_d;
      idx_q      <= idx_d;
      iss_en_q   <= iss_en_d;
      ret_vld_q  <= ret_vld_d;
      ret_addr_q <= ret_addr_d;
      ret_idx_q  <= ret_idx_d;
      ret_last_q <= ret_last_d;
    end
  end

  assign iss_en_o   = iss_en_q;
  assign iss_addr_o = w_iss_addr;
  assign iss_idx_o  = idx_q;
  assign ret_vld_o  = ret_vld_q;
  assign ret_addr_o = ret_addr_q;
  assign ret_idx_o  = ret_idx_q;
  assign ret_last_o = ret_last_q;

endmodule : vls_addr_gen
`default_nettype wire

// File: rtl/vls_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vls_sequencer
// Description : Sequences VLD/VST: moves NELEM elements between the memory
//               port and one vector register through the serial vector port,
//               one element per cycle with a two-stage issue/retire pipeline.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module vls_sequencer import vls_sequencer_pkg::*; #(
  parameter int unsigned NELEM = C_VLS_NELEM,
  parameter int unsigned WIDTH = C_VLS_WIDTH,
  parameter int unsigned AW    = C_VLS_AW,
  parameter int unsigned EW    = C_VLS_EW
) (
  input  logic             Clk1,
  input  logic             Reset,
  input  logic             Start,
  input  logic             IsStore,
  input  logic [AW-1:0]    BaseAddr,
  input  logic [5:0]       Offset,
  input  logic [2:0]       VRegSel,
  output logic             Busy,
  output logic             Done,
  output logic [AW-1:0]    Addr,
  output logic             RD,
  output logic             WR,
  output logic [WIDTH-1:0] DataOut,
  input  logic [WIDTH-1:0] DataIn,
  output logic [2:0]       VAddr,
  output logic [EW-1:0]    VElem,
  output logic             VRD_s,
  output logic             VWR_s,
  output logic [WIDTH-1:0] VInS,
  input  logic [WIDTH-1:0] VOutS
);

  vls_state_e state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [2:0] vsel_q, vsel_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [2:0]       vaddr_q, vaddr_d;
  logic [EW-1:0]    velem_q, velem_d;
  logic             vrd_q, vrd_d;
  logic             vwr_q, vwr_d;
  logic [WIDTH-1:0] vins_q, vins_d;

  logic          w_load;
  logic          w_is_vst;
  logic          w_iss_en;
  logic [AW-1:0] w_iss_addr;
  logic [EW-1:0] w_iss_idx;
  logic          w_ret_vld;
  logic [AW-1:0] w_ret_addr;
  logic [EW-1:0] w_ret_idx;
  logic          w_ret_last;

  assign w_is_vst = (op_q == C_OP_VST);

  vls_addr_gen #(
    .NELEM (NELEM),
    .AW    (AW),
    .EW    (EW)
  ) u_addr_gen (
    .clk_i      (Clk1),
    .rst_i      (Reset),
    .load_i     (w_load),
    .base_i     (BaseAddr),
    .offset_i   (Offset),
    .iss_en_o   (w_iss_en),
    .iss_addr_o (w_iss_addr),
    .iss_idx_o  (w_iss_idx),
    .ret_vld_o  (w_ret_vld),
    .ret_addr_o (w_ret_addr),
    .ret_idx_o  (w_ret_idx),
    .ret_last_o (w_ret_last)
  );

  // FSM next state and next output values; outputs idle at zero unless a
  // phase drives them. Memory phase owns Addr, vector phase owns VElem.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vsel_d  = vsel_q;
    w_load  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    addr_d  = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    dout_d  = '0;
    vaddr_d = '0;
    velem_d = '0;
    vrd_d   = 1'b0;
    vwr_d   = 1'b0;
    vins_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          w_load  = 1'b1;
          op_d    = IsStore ? C_OP_VST : C_OP_VLD;
          vsel_d  = VRegSel;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        // Issue phase: VST reads the vector register, VLD reads memory
        if (w_iss_en) begin
          if (w_is_vst) begin
            vrd_d   = 1'b1;
            vaddr_d = vsel_q;
            velem_d = w_iss_idx;
          end else begin
            rd_d   = 1'b1;
            addr_d = w_iss_addr;
          end
        end
        // Retire phase: capture the data returned for last cycle's issue
        if (w_ret_vld) begin
          if (w_is_vst) begin
            wr_d   = 1'b1;
            addr_d = w_ret_addr;
            dout_d = VOutS;
          end else begin
            vwr_d   = 1'b1;
            vaddr_d = vsel_q;
            velem_d = w_ret_idx;
            vins_d  = DataIn;
          end
          if (w_ret_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides any concurrent Start
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      vsel_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      vaddr_q <= '0;
      velem_q <= '0;
      vrd_q   <= 1'b0;
      vwr_q   <= 1'b0;
      vins_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vsel_q  <= vsel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      vaddr_q <= vaddr_d;
      velem_q <= velem_d;
      vrd_q   <= vrd_d;
      vwr_q   <= vwr_d;
      vins_q  <= vins_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Addr    = addr_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign DataOut = dout_q;
  assign VAddr   = vaddr_q;
  assign VElem   = velem_q;
  assign VRD_s   = vrd_q;
  assign VWR_s   = vwr_q;
  assign VInS    = vins_q;

endmodule : vls_sequencer
`default_nettype wire

// File: tb/tb_vls_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vls_sequencer
// Description : Self-checking bench for vls_sequencer. Memory returns
//               0xA000^Addr; a vector register file model serves the serial
//               port. Expected strobe events are queued at stimulus time and
//               popped as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vls_sequencer;

  logic        Clk1, Reset, Start, IsStore;
  logic [15:0] BaseAddr;
  logic [5:0]  Offset;
  logic [2:0]  VRegSel;
  logic        Busy, Done, RD, WR, VRD_s, VWR_s;
  logic [15:0] Addr, DataOut, DataIn, VInS, VOutS;
  logic [2:0]  VAddr;
  logic [3:0]  VElem;

  vls_sequencer dut (
    .Clk1(Clk1), .Reset(Reset), .Start(Start), .IsStore(IsStore),
    .BaseAddr(BaseAddr), .Offset(Offset), .VRegSel(VRegSel),
    .Busy(Busy), .Done(Done), .Addr(Addr), .RD(RD), .WR(WR),
    .DataOut(DataOut), .DataIn(DataIn), .VAddr(VAddr), .VElem(VElem),
    .VRD_s(VRD_s), .VWR_s(VWR_s), .VInS(VInS), .VOutS(VOutS)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  // Environment models
  logic [15:0] vreg     [0:7][0:15];
  logic [15:0] exp_vreg [0:7][0:15];
  assign DataIn = 16'hA000 ^ Addr;
  assign VOutS  = vreg[VAddr][VElem];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [2:0]  sel;
    logic [3:0]  elem;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  ev_t q_mem[$];
  ev_t q_vec[$];
  int  checks = 0;
  int  errors = 0;
  time t_e0   = 0;

  // Scoreboard consumer: every strobe must match the next queued event
  always @(negedge Clk1) begin
    int  cyc;
    ev_t e;
    cyc = int'(($time - t_e0 - 5) / 10);
    if (RD || WR) begin
      checks++;
      if (RD && WR) begin
        errors++;
        $display("FAIL mem_strobes both RD and WR high at cycle %0d", cyc);
      end else if (q_mem.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected RD=%0b WR=%0b Addr=%h at cycle %0d", RD, WR, Addr, cyc);
      end else begin
        e = q_mem.pop_front();
        if (WR !== e.wr || Addr !== e.addr || (e.wr && DataOut !== e.data) || cyc != e.cyc)
        begin
          errors++;
          $display("FAIL mem_event got WR=%0b Addr=%h DataOut=%h cyc=%0d need WR=%0b Addr=%h DataOut=%h cyc=%0d",
                   WR, Addr, DataOut, cyc, e.wr, e.addr, e.data, e.cyc);
        end
      end
    end
    if (VRD_s || VWR_s) begin
      checks++;
      if (VRD_s && VWR_s) begin
        errors++;
        $display("FAIL vec_strobes both VRD_s and VWR_s high at cycle %0d", cyc);
      end else if (q_vec.size() == 0) begin
        errors++;
        $display("FAIL vec_unexpected VRD=%0b VWR=%0b VElem=%0d at cycle %0d", VRD_s, VWR_s, VElem, cyc);
      end else begin
        e = q_vec.pop_front();
        if (VWR_s !== e.wr || VAddr !== e.sel || VElem !== e.elem ||
            (e.wr && VInS !== e.data) || cyc != e.cyc) begin
          errors++;
          $display("FAIL vec_event got VWR=%0b V%0d[%0d] VInS=%h cyc=%0d need VWR=%0b V%0d[%0d] VInS=%h cyc=%0d",
                   VWR_s, VAddr, VElem, VInS, cyc, e.wr, e.sel, e.elem, e.data, e.cyc);
        end
      end
      if (VWR_s) vreg[VAddr][VElem] = VInS;
    end
  end

  // Queue the strobe events a transfer must produce; cyc0 is its accept edge
  task automatic push_exp(input logic st, input logic [15:0] ea, input logic [2:0] sel,
                          input int n_iss, input int n_ret, input int cyc0);
    ev_t e;
    for (int k = 0; k < n_iss; k++) begin
      e.wr = 1'b0; e.addr = ea + 16'(k); e.sel = sel; e.elem = 4'(k);
      e.data = '0; e.cyc = cyc0 + k + 1;
      if (st) q_vec.push_back(e); else q_mem.push_back(e);
    end
    for (int k = 0; k < n_ret; k++) begin
      e.wr = 1'b1; e.addr = ea + 16'(k); e.sel = sel; e.elem = 4'(k);
      e.cyc = cyc0 + k + 2;
      if (st) begin
        e.data = exp_vreg[sel][k];
        q_mem.push_back(e);
      end else begin
        e.data = 16'hA000 ^ (ea + 16'(k));
        exp_vreg[sel][k] = e.data;
        q_vec.push_back(e);
      end
    end
  endtask

  // Pulse Start for one edge, then scramble the latched inputs
  task automatic start_xfer(input logic st, input logic [15:0] base,
                            input logic [5:0] off, input logic [2:0] sel);
    @(negedge Clk1);
    IsStore = st; BaseAddr = base; Offset = off; VRegSel = sel; Start = 1'b1;
    @(posedge Clk1);
    t_e0 = $time;
    @(negedge Clk1);
    Start = 1'b0; IsStore = ~st;
    BaseAddr = 16'($urandom); Offset = 6'($urandom); VRegSel = 3'($urandom);
  endtask

  // Observe cycles 1..30 after acceptance
  task automatic watch(output int done_cyc, output int n_done, output int n_busy);
    done_cyc = -1; n_done = 0; n_busy = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clk1);
      if (Done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (Busy === 1'b1) n_busy++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; IsStore = 1'b0;
    BaseAddr = 16'h1234; Offset = 6'd1; VRegSel = 3'd1;
    repeat (3) @(negedge Clk1);
    checks++;
    if ({Busy, Done, Addr, RD, WR, DataOut, VAddr, VElem, VRD_s, VWR_s, VInS} !== '0) begin
      errors++;
      $display("FAIL reset_outputs Busy=%0b Done=%0b Addr=%h RD=%0b WR=%0b VElem=%0d need all 0",
               Busy, Done, Addr, RD, WR, VElem);
    end
    Start = 1'b0; Reset = 1'b0;
    repeat (2) @(negedge Clk1);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle Busy=%0b need 0", Busy);
    end
  endtask

  task automatic test_xfer(input string name, input logic st, input logic [15:0] base,
                           input logic [5:0] off, input logic [2:0] sel);
    int dc, nd, nb;
    push_exp(st, base + {10'd0, off}, sel, 16, 16, 0);
    start_xfer(st, base, off, sel);
    watch(dc, nd, nb);
    checks++;
    if (dc != 18 || nd != 1) begin
      errors++;
      $display("FAIL %s_done first Done cycle=%0d pulses=%0d need cycle 18 pulses 1", name, dc, nd);
    end
    checks++;
    if (nb != 18) begin
      errors++;
      $display("FAIL %s_busy Busy cycles=%0d need 18", name, nb);
    end
    checks++;
    if (q_mem.size() != 0 || q_vec.size() != 0) begin
      errors++;
      $display("FAIL %s_missing pending mem=%0d vec=%0d need 0", name, q_mem.size(), q_vec.size());
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (vreg[sel][k] !== exp_vreg[sel][k]) begin
        errors++;
        $display("FAIL %s_vreg V%0d[%0d]=%h need %h", name, sel, k, vreg[sel][k], exp_vreg[sel][k]);
      end
    end
  endtask

  task automatic test_vld();
    test_xfer("vld", 1'b0, 16'h0100, 6'd5, 3'd3);
  endtask

  task automatic test_vst();
    for (int k = 0; k < 16; k++) begin
      vreg[6][k] = 16'h1000 + 16'(k);
      exp_vreg[6][k] = 16'h1000 + 16'(k);
    end
    test_xfer("vst", 1'b1, 16'h0200, 6'd0, 3'd6);
  endtask

  task automatic test_wrap();
    test_xfer("wrap", 1'b0, 16'hFFF0, 6'd8, 3'd1);
  endtask

  task automatic test_reset_mid();
    int nd;
    for (int k = 0; k < 16; k++) begin
      vreg[2][k] = 16'h5500 + 16'(k);
      exp_vreg[2][k] = 16'h5500 + 16'(k);
    end
    push_exp(1'b0, 16'h0310, 3'd2, 8, 7, 0);
    start_xfer(1'b0, 16'h0300, 6'h10, 3'd2);
    repeat (8) @(negedge Clk1);
    Reset = 1'b1;
    @(negedge Clk1);
    checks++;
    if ({Busy, Done, Addr, RD, WR, DataOut, VAddr, VElem, VRD_s, VWR_s, VInS} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs Busy=%0b RD=%0b VWR=%0b Addr=%h need all 0", Busy, RD, VWR_s, Addr);
    end
    Reset = 1'b0;
    nd = 0;
    repeat (25) @(negedge Clk1) if (Done === 1'b1) nd++;
    checks++;
    if (nd != 0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_done Done pulses=%0d Busy=%0b need 0 and 0", nd, Busy);
    end
    checks++;
    if (q_mem.size() != 0 || q_vec.size() != 0) begin
      errors++;
      $display("FAIL rstmid_missing pending mem=%0d vec=%0d need 0", q_mem.size(), q_vec.size());
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (vreg[2][k] !== exp_vreg[2][k]) begin
        errors++;
        $display("FAIL rstmid_vreg V2[%0d]=%h need %h", k, vreg[2][k], exp_vreg[2][k]);
      end
    end
  endtask

  task automatic test_start_held();
    int d1, d2, nd;
    logic busy19;
    d1 = -1; d2 = -1; nd = 0; busy19 = 1'b0;
    push_exp(1'b0, 16'h0403, 3'd5, 16, 16, 0);
    push_exp(1'b0, 16'h0403, 3'd5, 16, 16, 19);
    @(negedge Clk1);
    IsStore = 1'b0; BaseAddr = 16'h0400; Offset = 6'd3; VRegSel = 3'd5; Start = 1'b1;
    @(posedge Clk1);
    t_e0 = $time;
    for (int c = 0; c <= 37; c++) begin
      @(negedge Clk1);
      if (Done === 1'b1) begin
        nd++;
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
      if (c == 19) busy19 = Busy;
      if (c == 37) Reset = 1'b1;
    end
    @(negedge Clk1);
    checks++;
    if (Busy !== 1'b0 || RD !== 1'b0 || VRD_s !== 1'b0) begin
      errors++;
      $display("FAIL held_rst_start Busy=%0b RD=%0b need 0 0", Busy, RD);
    end
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clk1);
    checks++;
    if (d1 != 18 || d2 != 37 || nd != 2) begin
      errors++;
      $display("FAIL held_done Done cycles=%0d,%0d pulses=%0d need 18,37 pulses 2", d1, d2, nd);
    end
    checks++;
    if (busy19 !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL held_busy Busy@19=%0b Busy_end=%0b need 1 0", busy19, Busy);
    end
    checks++;
    if (q_mem.size() != 0 || q_vec.size() != 0) begin
      errors++;
      $display("FAIL held_missing pending mem=%0d vec=%0d need 0", q_mem.size(), q_vec.size());
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 16; k++) begin
        vreg[r][k] = '0;
        exp_vreg[r][k] = '0;
      end
    test_reset();
    test_vld();
    test_vst();
    test_wrap();
    test_reset_mid();
    test_start_held();
    repeat (3) @(negedge Clk1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vls_sequencer
`default_nettype wire
